// File: rtl/spart_driver_if.sv
// SPART processor-side control bus: chip select, direction, register address
// and the receive/transmit status flags coming back from the SPART.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor, polls rda and streams received
// bytes out as one-cycle strobes. Define SPART_DRIVER_ECHO_EN to echo bytes back via a 4-entry FIFO.
module spart_driver #(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     br_cfg,
  spart_driver_if.master bus,
  inout  wire  [7:0]     databus,
  output logic [7:0]     rx_byte,
  output logic           rx_valid
);

  localparam int unsigned DIV_4800  = CLK_HZ / (16 * 4800)  - 1;
  localparam int unsigned DIV_9600  = CLK_HZ / (16 * 9600)  - 1;
  localparam int unsigned DIV_19200 = CLK_HZ / (16 * 19200) - 1;
  localparam int unsigned DIV_38400 = CLK_HZ / (16 * 38400) - 1;

  typedef enum logic [2:0] {PROG_LO, PROG_HI, IDLE, RX_RD, TX_WR} state_t;

  state_t      state, state_nxt;
  logic        run;
  logic [1:0]  cfg_q;
  logic [15:0] div;
  logic        iocs_c, iorw_c, drv;
  logic [1:0]  ioaddr_c;
  logic [7:0]  dout;
  logic        rd_acc;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_head;

  always_comb begin
    case (br_cfg)
      2'b00:   div = 16'(DIV_4800);
      2'b01:   div = 16'(DIV_9600);
      2'b10:   div = 16'(DIV_19200);
      default: div = 16'(DIV_38400);
    endcase
  end

  // run holds the bus quiet for the first cycle after reset so PROG_LO
  // appears on the first edge following release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PROG_LO;
      run   <= 1'b0;
      cfg_q <= 2'b00;
    end else begin
      run <= 1'b1;
      if (run) state <= state_nxt;
      if (run && state == PROG_HI) cfg_q <= br_cfg;
    end
  end

  always_comb begin
    state_nxt = state;
    iocs_c    = 1'b0;
    iorw_c    = 1'b1;
    ioaddr_c  = 2'b00;
    drv       = 1'b0;
    dout      = 8'h00;
    rd_acc    = 1'b0;
    if (run) begin
      case (state)
        PROG_LO: begin
          iocs_c    = 1'b1;
          iorw_c    = 1'b0;
          ioaddr_c  = 2'b10;
          drv       = 1'b1;
          dout      = div[7:0];
          state_nxt = PROG_HI;
        end
        PROG_HI: begin
          iocs_c    = 1'b1;
          iorw_c    = 1'b0;
          ioaddr_c  = 2'b11;
          drv       = 1'b1;
          dout      = div[15:8];
          state_nxt = IDLE;
        end
        IDLE: begin
          if (br_cfg != cfg_q)               state_nxt = PROG_LO;
          else if (bus.rda && !fifo_full)    state_nxt = RX_RD;
          else if (!fifo_empty && bus.tbr)   state_nxt = TX_WR;
        end
        RX_RD: begin
          iocs_c    = 1'b1;
          rd_acc    = 1'b1;
          state_nxt = IDLE;
        end
        TX_WR: begin
          iocs_c    = 1'b1;
          iorw_c    = 1'b0;
          drv       = 1'b1;
          dout      = fifo_head;
          state_nxt = IDLE;
        end
        default: state_nxt = PROG_LO;
      endcase
    end
  end

  assign bus.iocs   = iocs_c;
  assign bus.iorw   = iorw_c;
  assign bus.ioaddr = ioaddr_c;
  assign databus    = drv ? dout : 8'hzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= rd_acc;
      if (rd_acc) rx_byte <= databus;
    end
  end

`ifdef SPART_DRIVER_ECHO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       pop;

  // RX_RD and TX_WR are distinct states, so push and pop never coincide.
  assign pop = run && (state == TX_WR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else if (rd_acc) begin
      wr_ptr <= wr_ptr + 2'd1;
      count  <= count + 3'd1;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 2'd1;
      count  <= count - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) fifo_mem[wr_ptr] <= databus;
  end

  assign fifo_full  = (count == 3'd4);
  assign fifo_empty = (count == 3'd0);
  assign fifo_head  = fifo_mem[rd_ptr];
`else
  assign fifo_full  = 1'b0;
  assign fifo_empty = 1'b1;
  assign fifo_head  = 8'h00;
`endif

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: SPART-side model on the bus, scoreboard queues for
// bus writes, received bytes and cycle snapshots checked by a monitor process.
module tb_spart_driver;
`ifdef SPART_DRIVER_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [4:0] bus_st;
    bit         chk_rxb;
    logic [7:0] rxb;
    bit         chk_rda;
    logic       rda;
    bit         fin;
  } snap_t;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic [1:0] br_cfg  = 2'b01;
  wire  [7:0] databus;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] rd_data = 8'h00;
  logic       rd_seen = 1'b0;
  logic       found;

  logic [7:0] spart_q[$];
  logic [9:0] exp_wr[$];
  logic [7:0] exp_rx[$];
  snap_t      exp_snap[$];

  int checks   = 0;
  int failures = 0;

  spart_driver_if bus();

  spart_driver #(.CLK_HZ(100000000)) dut (
    .clk     (clk),
    .rst     (rst),
    .br_cfg  (br_cfg),
    .bus     (bus),
    .databus (databus),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid)
  );

  // SPART drives the data bus only while the master reads it
  assign databus = (bus.iocs && bus.iorw) ? rd_data : 8'hzz;

  always #5 clk = ~clk;

  task automatic snap(input string name, input logic iocs, input logic iorw,
                      input logic [1:0] addr, input logic rxv,
                      input bit chk_rxb = 1'b0, input logic [7:0] rxb = 8'h00,
                      input bit chk_rda = 1'b0, input logic rda = 1'b0,
                      input bit fin = 1'b0);
    snap_t s;
    s.name    = name;
    s.bus_st  = {iocs, iorw, addr, rxv};
    s.chk_rxb = chk_rxb;
    s.rxb     = rxb;
    s.chk_rda = chk_rda;
    s.rda     = rda;
    s.fin     = fin;
    exp_snap.push_back(s);
  endtask

  // One cycle step plus the SPART model: a byte read in one cycle leaves the
  // receive buffer during the following cycle.
  task automatic tick();
    @(negedge clk);
    #2;
    if (rd_seen && spart_q.size() > 0) void'(spart_q.pop_front());
    rd_seen = rst && bus.iocs && bus.iorw && (bus.ioaddr == 2'b00);
    bus.rda = (spart_q.size() > 0);
    rd_data = (spart_q.size() > 0) ? spart_q[0] : 8'h00;
  endtask

  task automatic offer(input logic [7:0] b);
    spart_q.push_back(b);
    bus.rda = 1'b1;
    rd_data = spart_q[0];
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_wr.size() > 0 || exp_rx.size() > 0); i++) tick();
  endtask

  always begin
    snap_t      s;
    logic [9:0] e;
    logic [7:0] r;
    @(negedge clk or negedge rst);
    #1;
    if (rst && bus.iocs && !bus.iorw) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL bus_write: unexpected write addr=%b data=%h", bus.ioaddr, databus);
      end else begin
        e = exp_wr.pop_front();
        if ({bus.ioaddr, databus} !== e) begin
          failures++;
          $display("FAIL bus_write: got addr=%b data=%h, want addr=%b data=%h",
                   bus.ioaddr, databus, e[9:8], e[7:0]);
        end
      end
    end
    if (rst && rx_valid) begin
      checks++;
      if (exp_rx.size() == 0) begin
        failures++;
        $display("FAIL rx_byte: unexpected rx_valid with rx_byte=%h", rx_byte);
      end else begin
        r = exp_rx.pop_front();
        if (rx_byte !== r) begin
          failures++;
          $display("FAIL rx_byte: got %h, want %h", rx_byte, r);
        end
      end
    end
    if (exp_snap.size() > 0) begin
      s = exp_snap.pop_front();
      checks++;
      if (s.fin) begin
        if (exp_wr.size() != 0 || exp_rx.size() != 0) begin
          failures++;
          $display("FAIL drain: pending writes=%0d bytes=%0d, want 0 and 0",
                   exp_wr.size(), exp_rx.size());
        end
      end else begin
        if ({bus.iocs, bus.iorw, bus.ioaddr, rx_valid} !== s.bus_st) begin
          failures++;
          $display("FAIL %s: iocs,iorw,ioaddr,rx_valid got %b, want %b", s.name,
                   {bus.iocs, bus.iorw, bus.ioaddr, rx_valid}, s.bus_st);
        end
        if (s.chk_rxb) begin
          checks++;
          if (rx_byte !== s.rxb) begin
            failures++;
            $display("FAIL %s: rx_byte got %h, want %h", s.name, rx_byte, s.rxb);
          end
        end
        if (s.chk_rda) begin
          checks++;
          if (bus.rda !== s.rda) begin
            failures++;
            $display("FAIL %s: rda (byte left unread) got %b, want %b", s.name, bus.rda, s.rda);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at 200000ns, want finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rda = 1'b0;
    bus.tbr = 1'b0;

    // reset state, then divisor programming for 9600 baud (650 = 16'h028A)
    tick();
    snap("reset_state", 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    exp_wr.push_back({2'b10, 8'h8A});
    exp_wr.push_back({2'b11, 8'h02});
    snap("prog_lo", 1'b1, 1'b0, 2'b10, 1'b0);
    rst = 1'b1;
    tick();
    snap("prog_hi", 1'b1, 1'b0, 2'b11, 1'b0);
    tick();
    snap("idle_after_prog", 1'b0, 1'b1, 2'b00, 1'b0);
    tick();
    bus.tbr = 1'b1;
    repeat (3) tick();

    // single receive with cycle-exact latency
    offer(8'h5A);
    exp_rx.push_back(8'h5A);
    if (ECHO) exp_wr.push_back({2'b00, 8'h5A});
    snap("rx_rd_cycle", 1'b1, 1'b1, 2'b00, 1'b0);
    tick();
    snap("rx_valid_cycle", 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'h5A);
    tick();
    snap("after_rx_valid", ECHO, !ECHO, 2'b00, 1'b0, 1'b1, 8'h5A);
    tick();
    repeat (4) tick();

    offer(8'h31);
    exp_rx.push_back(8'h31);
    if (ECHO) exp_wr.push_back({2'b00, 8'h31});
    repeat (8) tick();

    // five bytes while the transmitter is busy
    bus.tbr = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      offer(8'(b));
      exp_rx.push_back(8'(b));
      if (ECHO) exp_wr.push_back({2'b00, 8'(b)});
    end
    repeat (30) tick();
    snap("full_stall", 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, ECHO);
    tick();
    bus.tbr = 1'b1;
    drain();

    // reprogram to 38400 (161 = 16'h00A1) with bytes held in the FIFO
    bus.tbr = 1'b0;
    offer(8'h77);
    offer(8'h88);
    exp_rx.push_back(8'h77);
    exp_rx.push_back(8'h88);
    repeat (10) tick();
    br_cfg = 2'b11;
    exp_wr.push_back({2'b10, 8'hA1});
    exp_wr.push_back({2'b11, 8'h00});
    if (ECHO) begin
      exp_wr.push_back({2'b00, 8'h77});
      exp_wr.push_back({2'b00, 8'h88});
    end
    repeat (10) tick();
    bus.tbr = 1'b1;
    drain();

    // reset in the middle of an access
    bus.tbr = 1'b0;
    offer(8'h99);
    if (ECHO) begin
      exp_rx.push_back(8'h99);
      exp_wr.push_back({2'b00, 8'h99});
      repeat (6) tick();
      bus.tbr = 1'b1;
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.iocs && bus.ioaddr == 2'b00 && (bus.iorw == !ECHO)) found = 1'b1;
      else tick();
    end
    if (found) snap("rst_mid_access", 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00);
    else       snap("access_before_reset", 1'b1, !ECHO, 2'b00, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    exp_wr.push_back({2'b10, 8'hA1});
    exp_wr.push_back({2'b11, 8'h00});
    snap("prog_lo_restart", 1'b1, 1'b0, 2'b10, 1'b0);
    rst = 1'b1;
    tick();
    snap("prog_hi_restart", 1'b1, 1'b0, 2'b11, 1'b0);
    tick();
    bus.tbr = 1'b1;
    repeat (20) tick();
    snap("idle_fifo_cleared", 1'b0, 1'b1, 2'b00, 1'b0);
    tick();

    snap("drain", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spart_driver.md
# spart_driver

Bus-master state machine that sits directly on the processor side of the SPART bus (iocs/iorw/ioaddr/databus, rda/tbr). After reset it programs the baud divisor, then polls rda, reads each received byte and presents it as a one-cycle byte stream to the image-processing logic. Optionally it echoes every received byte back through the SPART transmitter via a 4-entry FIFO.

## Interface
- CLK_HZ, 100000000: system clock frequency in Hz.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- br_cfg  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
- iocs  out  1  SPART chip select; high for exactly one cycle per bus access.
- iorw  out  1  1=read, 0=write.
- ioaddr  out  2  00=TX/RX buffer, 10=divisor low byte, 11=divisor high byte.
- databus  inout  8  driven by this block only when iocs=1 and iorw=0; Z otherwise.
- rda  in  1  SPART receive data available.
- tbr  in  1  SPART transmit buffer ready.
- rx_byte  out  8  last byte read from SPART.
- rx_valid  out  1  one-cycle strobe: rx_byte is new.

## Operation
- Divisor DIV = CLK_HZ/(16*baud) - 1, integer truncation, 16 bits; at 100 MHz: 1301, 650, 324, 161.
- States: PROG_LO, PROG_HI, IDLE, RX_RD, TX_WR.
- PROG_LO: iocs=1, iorw=0, ioaddr=10, databus=DIV[7:0] -> PROG_HI.
- PROG_HI: iocs=1, iorw=0, ioaddr=11, databus=DIV[15:8]; latch br_cfg into cfg_q -> IDLE.
- IDLE: all bus outputs inactive (iocs=0, iorw=1, ioaddr=00, databus Z). Priority: (1) br_cfg != cfg_q -> PROG_LO; (2) rda=1 and FIFO not full -> RX_RD; (3) FIFO not empty and tbr=1 -> TX_WR; else stay.
- RX_RD: iocs=1, iorw=1, ioaddr=00; sample databus at end of cycle into rx_byte; push into echo FIFO; -> IDLE.
- TX_WR: iocs=1, iorw=0, ioaddr=00, databus=FIFO head; pop FIFO; -> IDLE.
- Every access is followed by at least one IDLE cycle, so SPART rda/tbr updates are seen before the next decision.
- Echo FIFO: 4 entries, 2-bit pointers wrap 3->0, 3-bit count. Full: no RX_RD issued; rda stays high and the byte waits in SPART. Push and pop never occur in the same cycle.
- br_cfg change is acted on only in IDLE; an in-flight access completes first. FIFO contents are kept across reprogramming.

## Timing
- Reset (rst=0): state=PROG_LO, iocs=0, iorw=1, ioaddr=00, databus Z, rx_byte=8'h00, rx_valid=0, FIFO empty, cfg_q=00.
- First rising edge after rst release enters PROG_LO outputs; PROG_HI on the next cycle; IDLE on the third.
- rda seen high in IDLE at cycle N: RX_RD at N+1; rx_valid=1 and rx_byte valid at N+2 for exactly one cycle.
- Minimum receive-to-echo: TX_WR no earlier than 2 cycles after RX_RD.
- rda and tbr both high with non-empty, non-full FIFO: RX_RD wins; TX_WR follows after one IDLE cycle.
- Reset asserted mid-access: outputs go to reset values immediately (asynchronous); databus released the same instant.

## Configuration
- SPART_DRIVER_ECHO_EN defined: echo FIFO and TX_WR state present as above.
- Not defined: no FIFO, TX_WR never entered, iorw never 0 outside PROG states; RX_RD issued whenever rda=1 in IDLE (never stalls).

## Test plan
- Reset release, br_cfg=01 -> writes 8'h8A at ioaddr 10, then 8'h02 at 11, on consecutive cycles; then IDLE with iocs=0.
- rda pulse with SPART driving 8'h5A -> one read at ioaddr 00; rx_valid high one cycle with rx_byte=8'h5A two cycles after rda seen.
- ECHO_EN, tbr=1, receive 8'h31 -> write of 8'h31 at ioaddr 00 following the read.
- ECHO_EN, tbr=0, five bytes 01..05 offered -> four reads, FIFO full, fifth byte not read while full; tbr=1 -> echoes 01,02,03,04 in order, then 05 read and echoed.
- br_cfg 01->11 while idle -> reprogram writes 8'hA1 (low) and 8'h00 (high); FIFO contents intact.
- rst asserted during TX_WR -> iocs=0, databus Z same cycle; after release, PROG_LO restarts with FIFO empty.
